// File: rtl/key_debounce_sched_if.sv
// Key debounce bus: raw key levels in, debounced levels, strobes and
// timer status out. The master side drives the raw keys; the slave side
// is the debounce controller.
interface key_debounce_sched_if #(
    parameter int NKEYS    = 4,
    parameter int IDX_BITS = 2
);
    logic [NKEYS-1:0]    key_i;
    logic [NKEYS-1:0]    key_o;
    logic [NKEYS-1:0]    press_o;
    logic [NKEYS-1:0]    release_o;
    logic                busy_o;
    logic [IDX_BITS-1:0] active_o;

    modport master (
        output key_i,
        input  key_o, press_o, release_o, busy_o, active_o
    );

    modport slave (
        input  key_i,
        output key_o, press_o, release_o, busy_o, active_o
    );
endinterface

// File: rtl/key_debounce_sched.sv
// Time-multiplexed key debouncer: one shared stability timer is handed
// round-robin to whichever key differs from its debounced level. A key
// commits after NUMBER consecutive stable cycles; returning to the old
// level while timed aborts the attempt without any event.
module key_debounce_sched #(
    parameter int                NKEYS    = 4,
    parameter int                IDX_BITS = 2,
    parameter int                NBITS    = 24,
    parameter logic [NBITS-1:0]  NUMBER   = 24'd10_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    key_debounce_sched_if.slave    bus
);

    typedef enum logic [0:0] {
        SCAN   = 1'b0,
        TIMING = 1'b1
    } state_t;

    localparam logic [NKEYS-1:0] ONE_K  = {{(NKEYS-1){1'b0}}, 1'b1};
    localparam logic [NKEYS-1:0] ZERO_K = {NKEYS{1'b0}};

    // First requesting key at or after 'start', wrapping past NKEYS-1.
    function automatic logic [IDX_BITS-1:0] rr_pick(
        input logic [NKEYS-1:0]    req,
        input logic [IDX_BITS-1:0] start
    );
        logic [IDX_BITS-1:0] pick;
        logic                found;
        int                  pos;
        pick  = {IDX_BITS{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            pos = int'(start) + i;
            if (pos >= NKEYS) begin
                pos = pos - NKEYS;
            end else begin
                pos = pos;
            end
            if (!found && (|(req & (ONE_K << pos)))) begin
                found = 1'b1;
                pick  = IDX_BITS'(pos);
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Next key index, wrapping at NKEYS even when NKEYS is not a power of two.
    function automatic logic [IDX_BITS-1:0] wrap_inc(input logic [IDX_BITS-1:0] i);
        if (i == IDX_BITS'(NKEYS - 1)) begin
            return {IDX_BITS{1'b0}};
        end else begin
            return i + {{(IDX_BITS-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t              state_q,   state_d;
    logic [NBITS-1:0]    count_q,   count_d;
    logic [IDX_BITS-1:0] ptr_q,     ptr_d;
    logic [NKEYS-1:0]    sync1_q,   sync1_d;
    logic [NKEYS-1:0]    sync2_q,   sync2_d;
    logic [NKEYS-1:0]    key_q,     key_d;
    logic [NKEYS-1:0]    press_q,   press_d;
    logic [NKEYS-1:0]    release_q, release_d;
    logic                busy_q,    busy_d;
    logic [IDX_BITS-1:0] active_q,  active_d;   // doubles as the owning key index

    logic [NKEYS-1:0]    diff_s;
    logic [NKEYS-1:0]    onehot_s;

    // Scheduler / timer next-state and registered-output logic.
    always_comb begin
        sync1_d   = bus.key_i;
        sync2_d   = sync1_q;
        state_d   = state_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        key_d     = key_q;
        press_d   = ZERO_K;
        release_d = ZERO_K;
        busy_d    = busy_q;
        active_d  = active_q;
        diff_s    = sync2_q ^ key_q;
        onehot_s  = ONE_K << active_q;

        case (state_q)
            SCAN: begin
                if (diff_s != ZERO_K) begin
                    state_d  = TIMING;
                    count_d  = {NBITS{1'b0}};
                    busy_d   = 1'b1;
                    active_d = rr_pick(diff_s, ptr_q);
                end else begin
                    state_d = SCAN;
                end
            end
            TIMING: begin
                if (!(|(diff_s & onehot_s))) begin
                    // Key bounced back to its committed level: give up the timer.
                    state_d  = SCAN;
                    ptr_d    = wrap_inc(active_q);
                    busy_d   = 1'b0;
                    active_d = {IDX_BITS{1'b0}};
                end else if (count_q == (NUMBER - NBITS'(1'b1))) begin
                    // Stable long enough: the debounced level flips to the new value.
                    key_d = key_q ^ onehot_s;
                    if (|(sync2_q & onehot_s)) begin
                        press_d = onehot_s;
                    end else begin
                        release_d = onehot_s;
                    end
                    state_d  = SCAN;
                    ptr_d    = wrap_inc(active_q);
                    busy_d   = 1'b0;
                    active_d = {IDX_BITS{1'b0}};
                end else begin
                    count_d = count_q + NBITS'(1'b1);
                end
            end
            default: begin
                state_d  = SCAN;
                busy_d   = 1'b0;
                active_d = {IDX_BITS{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SCAN;
            count_q   <= {NBITS{1'b0}};
            ptr_q     <= {IDX_BITS{1'b0}};
            sync1_q   <= ZERO_K;
            sync2_q   <= ZERO_K;
            key_q     <= ZERO_K;
            press_q   <= ZERO_K;
            release_q <= ZERO_K;
            busy_q    <= 1'b0;
            active_q  <= {IDX_BITS{1'b0}};
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
            busy_q    <= busy_d;
            active_q  <= active_d;
        end
    end

    assign bus.key_o     = key_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;
    assign bus.busy_o    = busy_q;
    assign bus.active_o  = active_q;

endmodule

// File: tb/tb_key_debounce_sched.sv
// Bench for key_debounce_sched with NKEYS=4, NUMBER=4. A behavioural
// model predicts all outputs every cycle; directed checks pin the
// hand-computed edge numbers of each scenario.
module tb_key_debounce_sched;
    localparam int NK  = 4;
    localparam int IB  = 2;
    localparam int NUM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_debounce_sched_if #(.NKEYS(NK), .IDX_BITS(IB)) bus_if ();

    key_debounce_sched #(
        .NKEYS(NK), .IDX_BITS(IB), .NBITS(24), .NUMBER(24'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: synchronizer delay line, committed levels, the key
    // currently owning the timer (-1 when none) and how long it has been stable.
    logic [NK-1:0] m_s1 = '0, m_s2 = '0, m_key = '0, m_press = '0, m_rel = '0;
    logic [NK-1:0] m_d;
    int  m_owner = -1;
    int  m_age   = 0;
    int  m_ptr   = 0;
    bit  m_valid = 1'b0;
    logic [IB-1:0] m_act;

    // Inputs change just after posedge, so at negedge they are what the next
    // posedge will sample: compare first, then advance the model one edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                m_act = (m_owner >= 0) ? IB'(m_owner) : '0;
                chk("cycle{key,press,rel,busy,act}",
                    {17'd0, bus_if.key_o, bus_if.press_o, bus_if.release_o, bus_if.busy_o, bus_if.active_o},
                    {17'd0, m_key, m_press, m_rel, (m_owner >= 0), m_act});
            end
            if (rst) begin
                m_s1 = '0; m_s2 = '0; m_key = '0; m_press = '0; m_rel = '0;
                m_owner = -1; m_age = 0; m_ptr = 0; m_valid = 1'b1;
            end else begin
                m_press = '0;
                m_rel   = '0;
                if (m_owner < 0) begin
                    m_d = m_s2 ^ m_key;
                    for (int i = 0; i < NK; i++) begin
                        if (m_owner < 0 && m_d[(m_ptr + i) % NK]) begin
                            m_owner = (m_ptr + i) % NK;
                            m_age   = 0;
                        end
                    end
                end else if (m_s2[m_owner] == m_key[m_owner]) begin
                    m_ptr   = (m_owner + 1) % NK;
                    m_owner = -1;
                end else if (m_age == NUM - 1) begin
                    m_key[m_owner] = m_s2[m_owner];
                    if (m_s2[m_owner]) m_press[m_owner] = 1'b1;
                    else               m_rel[m_owner]   = 1'b1;
                    m_ptr   = (m_owner + 1) % NK;
                    m_owner = -1;
                end else begin
                    m_age++;
                end
                m_s2 = m_s1;
                m_s1 = bus_if.key_i;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.key_i = 4'b0000;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        bus_if.key_i = 4'b0000;
        // 1. reset
        tick(2);
        chk("reset key_o",     32'(bus_if.key_o),     32'h0);
        chk("reset press_o",   32'(bus_if.press_o),   32'h0);
        chk("reset release_o", 32'(bus_if.release_o), 32'h0);
        chk("reset busy_o",    32'(bus_if.busy_o),    32'h0);
        chk("reset active_o",  32'(bus_if.active_o),  32'h0);
        rst = 1'b0;

        // 2. clean press and release of key1
        bus_if.key_i = 4'b0010;
        tick(2);  chk("press busy before edge3", 32'(bus_if.busy_o), 32'h0);
        tick(1);  chk("press busy edge3",   32'(bus_if.busy_o),   32'h1);
                  chk("press active edge3", 32'(bus_if.active_o), 32'h1);
        tick(3);  chk("press key_o edge6",  32'(bus_if.key_o),    32'h0);
        tick(1);  chk("press key_o edge7",  32'(bus_if.key_o),    32'h2);
                  chk("press strobe edge7", 32'(bus_if.press_o),  32'h2);
        tick(1);  chk("press strobe edge8", 32'(bus_if.press_o),  32'h0);
                  chk("press busy edge8",   32'(bus_if.busy_o),   32'h0);
        bus_if.key_i = 4'b0000;
        tick(6);  chk("release strobe edge6", 32'(bus_if.release_o), 32'h0);
        tick(1);  chk("release strobe edge7", 32'(bus_if.release_o), 32'h2);
                  chk("release key_o edge7",  32'(bus_if.key_o),     32'h0);

        // 3. bounce on key2
        bus_if.key_i = 4'b0100;
        tick(2);
        bus_if.key_i = 4'b0000;
        tick(1);  chk("bounce busy edge3",   32'(bus_if.busy_o),   32'h1);
                  chk("bounce active edge3", 32'(bus_if.active_o), 32'h2);
        tick(2);  chk("bounce busy edge5",   32'(bus_if.busy_o),   32'h0);
        tick(4);  chk("bounce key_o",        32'(bus_if.key_o),    32'h0);

        // 4. contention key0 + key3 from ptr=0
        do_reset();
        bus_if.key_i = 4'b1001;
        tick(3);  chk("cont active edge3", 32'(bus_if.active_o), 32'h0);
                  chk("cont busy edge3",   32'(bus_if.busy_o),   32'h1);
        tick(4);  chk("cont key_o edge7",  32'(bus_if.key_o),    32'h1);
                  chk("cont press edge7",  32'(bus_if.press_o),  32'h1);
        tick(1);  chk("cont active edge8", 32'(bus_if.active_o), 32'h3);
                  chk("cont busy edge8",   32'(bus_if.busy_o),   32'h1);
        tick(3);  chk("cont key_o edge11", 32'(bus_if.key_o),    32'h1);
        tick(1);  chk("cont key_o edge12", 32'(bus_if.key_o),    32'h9);
                  chk("cont press edge12", 32'(bus_if.press_o),  32'h8);
        tick(1);

        // 5. round robin: key1 commits (ptr=2), then key0 + key2 together
        do_reset();
        bus_if.key_i = 4'b0010;
        tick(7);  chk("rr key1 commit", 32'(bus_if.key_o), 32'h2);
        tick(2);
        bus_if.key_i = 4'b0111;
        tick(3);  chk("rr active edge3",  32'(bus_if.active_o), 32'h2);
        tick(4);  chk("rr key_o edge7",   32'(bus_if.key_o),    32'h6);
                  chk("rr press edge7",   32'(bus_if.press_o),  32'h4);
        tick(5);  chk("rr key_o edge12",  32'(bus_if.key_o),    32'h7);
                  chk("rr press edge12",  32'(bus_if.press_o),  32'h1);
        tick(2);

        // 6. reset while key3 is being timed (count=2)
        do_reset();
        bus_if.key_i = 4'b1000;
        tick(5);  chk("mid busy edge5",   32'(bus_if.busy_o),   32'h1);
                  chk("mid active edge5", 32'(bus_if.active_o), 32'h3);
        rst = 1'b1;
        tick(1);  chk("mid rst key_o",    32'(bus_if.key_o),    32'h0);
                  chk("mid rst busy",     32'(bus_if.busy_o),   32'h0);
                  chk("mid rst press",    32'(bus_if.press_o),  32'h0);
        rst = 1'b0;
        tick(6);  chk("after rst key_o edge6", 32'(bus_if.key_o),   32'h0);
        tick(1);  chk("after rst key_o edge7", 32'(bus_if.key_o),   32'h8);
                  chk("after rst press edge7", 32'(bus_if.press_o), 32'h8);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_debounce_sched.md
Name: key_debounce_sched

Overview:
Time-multiplexed debounce controller. One shared debounce timer serves NKEYS board push-buttons, so each key needs no counter of its own. A round-robin scheduler picks which changed key gets the timer. The block drives the debounced key levels plus one-cycle press and release strobes to the CPU run/step and display control logic.

Parameters:
NKEYS, 4, number of keys served (2..8)
IDX_BITS, 2, width of the key index; 2^IDX_BITS >= NKEYS
NUMBER, 24'd10_000_000, stable cycles required before commit (0.1 s at 100 MHz); must be >= 2
NBITS, 24, timer width; NUMBER <= 2^NBITS-1

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-high reset
key_i  input  NKEYS  raw asynchronous key levels
key_o  output  NKEYS  debounced stable levels
press_o  output  NKEYS  one-cycle strobe when key_o[k] commits 0->1
release_o  output  NKEYS  one-cycle strobe when key_o[k] commits 1->0
busy_o  output  1  high while the timer is owned by a key (TIMING state)
active_o  output  IDX_BITS  index of the key being timed; 0 when idle

Behaviour:
- Reset: only one clock exists; rst is synchronous and active-high. rst has priority over all other logic. All outputs are registered.
- Reset values: key_o=0, press_o=0, release_o=0, busy_o=0, active_o=0. Also cleared: both synchronizer stages, count=0, rr pointer ptr=0, state=SCAN.
- Synchronizer: each key passes through two flops, sync1 then sync2. Only sync2 is used downstream.
- diff = sync2 ^ key_o, evaluated every cycle.
- SCAN state:
  - If diff==0, stay in SCAN.
  - Otherwise select the first set bit of diff, searching from ptr upward and wrapping past NKEYS-1 to 0.
  - Latch it as idx. Set count<=0, go to TIMING. busy_o<=1 and active_o<=idx.
- TIMING state, evaluated in this priority order:
  - (a) Bounce: sync2[idx]==key_o[idx] means the key returned to its old level. Abort: go to SCAN, set ptr<=idx+1 (wrapping), busy_o<=0, active_o<=0. No strobe.
  - (b) Commit: count==NUMBER-1. Set key_o[idx]<=sync2[idx]. Pulse press_o[idx] if the new level is 1, otherwise release_o[idx]. Set ptr<=idx+1 (wrapping), go to SCAN, busy_o<=0, active_o<=0.
  - (c) Otherwise count<=count+1.
- Strobes are high for exactly one cycle, in the same cycle key_o changes. At most one strobe bit is set in any cycle.
- Latency with no contention: count the first edge that samples the new key_i level as edge 1. key_o updates on edge NUMBER+3.
- Contention:
  - Keys changing while another key is being timed wait. They are served in later SCANs.
  - Worst-case latency for any key is about NKEYS*(NUMBER+1)+3 cycles.
- A key that changes and reverts before it is selected produces no event.
- key_o only ever changes in a commit cycle, one key at a time.
- Reset asserted mid-TIMING: the timer is discarded with no strobe and key_o returns to 0. A key still held after reset is debounced again from scratch.
- ptr wraps from NKEYS-1 to 0 even when NKEYS is not a power of two.
- count never exceeds NUMBER-1.

Test Plan:
Use NUMBER=4 and NKEYS=4 throughout.
1. Reset: key_i=4'b0000, hold rst for 2 cycles -> key_o=0, press_o=0, release_o=0, busy_o=0, active_o=0.
2. Clean press: key_i[1] rises and is held -> busy_o=1 and active_o=1 from edge 3. key_o=4'b0010 from edge 7. press_o=4'b0010 for that single cycle. Then drop key_i[1] -> release_o=4'b0010 7 edges later.
3. Bounce: key_i[2] high for 2 cycles, then low -> TIMING aborts. key_o and the strobes stay 0, and busy_o returns to 0.
4. Contention: key_i[0] and key_i[3] rise on the same cycle with ptr=0 -> key0 commits at edge 7. key3 is selected at edge 8 and commits at edge 12.
5. Round-robin: after key1 commits (ptr=2), key_i[0] and key_i[2] rise together -> key2 commits first, then key0 5 edges later.
6. Reset mid-operation: assert rst while count=2 with key_i[3] held high -> no strobe and key_o=0. After rst is released, key3 commits NUMBER+3 edges later.
